// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential sliced ALU.
//   op_e     - operation encoding on the 3-bit op port
//   state_e  - controller states (idle / slice run / result hold)
//   FLG_*    - bit positions inside the 4-bit {N, Z, C, V} flags word
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_AND    = 3'b010,
      OP_OR     = 3'b011,
      OP_XOR    = 3'b100,
      OP_ADC    = 3'b101,
      OP_SBB    = 3'b110,
      OP_PASS_A = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // Ops that go through the adder and report C/V.
   function automatic logic is_arith(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
   endfunction

   // Ops that add the inverted B operand.
   function automatic logic is_sub(input op_e op);
      return (op == OP_SUB) || (op == OP_SBB);
   endfunction

endpackage

// File: rtl/alu_seq_slice.sv
// alu_seq_slice: combinational SLICE_W-bit ALU slice.
//   op      - operation (alu_seq_pkg::op_e)
//   a, b    - operand slices
//   cin     - carry into bit 0 of the slice
//   y       - result slice
//   cout    - carry out of the slice MSB (0 for logic ops)
//   msb_cin - carry into the slice MSB, used for signed overflow
module alu_seq_slice
   import alu_seq_pkg::*;
#(
   parameter int SLICE_W = 4
) (
   input  op_e                op,
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] y,
   output logic               cout,
   output logic               msb_cin
);

   logic [SLICE_W-1:0] bx;
   logic [SLICE_W:0]   sum;

   always_comb begin
      bx      = b ^ {SLICE_W{is_sub(op)}};
      sum     = {1'b0, a} + {1'b0, bx} + {{SLICE_W{1'b0}}, cin};
      y       = '0;
      cout    = 1'b0;
      msb_cin = 1'b0;
      case (op)
         OP_AND:    y = a & b;
         OP_OR:     y = a | b;
         OP_XOR:    y = a ^ b;
         OP_PASS_A: y = a;
         default: begin
            y       = sum[SLICE_W-1:0];
            cout    = sum[SLICE_W];
            // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
            msb_cin = sum[SLICE_W-1] ^ a[SLICE_W-1] ^ bx[SLICE_W-1];
         end
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU that walks a WIDTH-bit operation SLICE_W bits per
// cycle, keeping the inter-slice carry in a register.
//   clk, reset          - clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake (op, a, b captured in IDLE)
//   op, a, b            - operation and operands
//   out_valid/out_ready - result handshake; result/flags held until taken
//   result, flags       - result and {N, Z, C, V}
// Optional build macro ALU_SEQ_SAT_EN: signed saturation of ADD/SUB/ADC/SBB.
//
// Operands shift right one slice per RUN cycle so the slice always works on
// bits [SLICE_W-1:0]; the result shifts in from the top. One extra DONE cycle
// settles flags and saturation before out_valid rises, keeping the
// saturation mux off the slice adder path.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SLICE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   generate
      if ((SLICE_W < 1) || (WIDTH % SLICE_W != 0)) begin : g_bad_width
         $error("alu_seq: WIDTH must be a positive multiple of SLICE_W");
      end
   endgenerate

   state_e             state, state_nxt;
   op_e                op_r;
   logic [WIDTH-1:0]   a_r, b_r, res_r, fin_res;
   logic [3:0]         flg_r, fin_flg;
   logic [CW-1:0]      cnt;
   logic               carry_r, c_flag, zacc, v_r, ovld_r;
   logic               arith, sat;
   logic [SLICE_W-1:0] s_y;
   logic               s_cout, s_mcin;

   alu_seq_slice #(.SLICE_W(SLICE_W)) u_slice (
      .op      (op_r),
      .a       (a_r[SLICE_W-1:0]),
      .b       (b_r[SLICE_W-1:0]),
      .cin     (carry_r),
      .y       (s_y),
      .cout    (s_cout),
      .msb_cin (s_mcin)
   );

   // Final result/flags from the fully assembled result register.
   always_comb begin
      arith = is_arith(op_r);
      sat   = 1'b0;
`ifdef ALU_SEQ_SAT_EN
      sat   = arith & v_r;
`endif
      fin_res = res_r;
      // A wrapped negative MSB means the true value overflowed positive.
      if (sat)
         fin_res = res_r[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
      fin_flg        = '0;
      fin_flg[FLG_N] = fin_res[WIDTH-1];
      fin_flg[FLG_Z] = zacc & ~sat;
      fin_flg[FLG_C] = arith & carry_r;
      fin_flg[FLG_V] = arith & v_r;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_RUN;
         end
         S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
         S_DONE: if (ovld_r && out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign out_valid = ovld_r;
   assign result    = res_r;
   assign flags     = flg_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         op_r    <= OP_ADD;
         a_r     <= '0;
         b_r     <= '0;
         res_r   <= '0;
         flg_r   <= '0;
         cnt     <= '0;
         carry_r <= 1'b0;
         c_flag  <= 1'b0;
         zacc    <= 1'b0;
         v_r     <= 1'b0;
         ovld_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               op_r  <= op_e'(op);
               a_r   <= a;
               b_r   <= b;
               cnt   <= '0;
               res_r <= '0;
               zacc  <= 1'b1;
               case (op_e'(op))
                  OP_SUB:         carry_r <= 1'b1;
                  OP_ADC, OP_SBB: carry_r <= c_flag;   // SBB: C=1 means no borrow
                  default:        carry_r <= 1'b0;
               endcase
            end
            S_RUN: begin
               a_r     <= a_r >> SLICE_W;
               b_r     <= b_r >> SLICE_W;
               res_r   <= (res_r >> SLICE_W) | (WIDTH'(s_y) << (WIDTH - SLICE_W));
               carry_r <= s_cout;
               zacc    <= zacc & (s_y == '0);
               v_r     <= s_cout ^ s_mcin;   // last slice's value is the one kept
               if (cnt != LAST) cnt <= cnt + 1'b1;
            end
            S_DONE: begin
               if (!ovld_r) begin
                  res_r  <= fin_res;
                  flg_r  <= fin_flg;
                  ovld_r <= 1'b1;
               end else if (out_ready) begin
                  ovld_r <= 1'b0;
                  c_flag <= flg_r[FLG_C];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=16, SLICE_W=4).
// A behavioural model (plain 17-bit arithmetic plus a carry-flag variable)
// predicts every result; one negedge process compares it with the DUT, and
// each vector also carries hand-computed literal expectations.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 16;

`ifdef ALU_SEQ_SAT_EN
   localparam logic [15:0] R_OVF  = 16'h7FFF;
   localparam logic [3:0]  F_OVF  = 4'b0001;
   localparam logic [15:0] R_SBBV = 16'h8000;
   localparam logic [3:0]  F_SBBV = 4'b1011;
`else
   localparam logic [15:0] R_OVF  = 16'h8000;
   localparam logic [3:0]  F_OVF  = 4'b1001;
   localparam logic [15:0] R_SBBV = 16'h7FFF;
   localparam logic [3:0]  F_SBBV = 4'b0011;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  a = '0, b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic [3:0]    flags;

   int checks = 0;
   int errors = 0;

   // model state
   bit            go = 1'b0;
   bit            pend = 1'b0;
   logic          cf = 1'b0;
   logic [15:0]   exp_res = '0;
   logic [3:0]    exp_flg = '0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W), .SLICE_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // {result, N, Z, C, V} from the operation's arithmetic meaning.
   function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] x,
                                         input logic [15:0] y, input logic c);
      logic [16:0] s;
      logic [15:0] yy, r;
      logic        ar, co, v;
      ar = 1'b1; yy = y; s = '0; r = '0; co = 1'b0; v = 1'b0;
      case (o)
         OP_ADD: s = 17'(x) + 17'(y);
         OP_SUB: begin yy = ~y; s = 17'(x) + 17'(yy) + 17'd1; end
         OP_ADC: s = 17'(x) + 17'(y) + 17'(c);
         OP_SBB: begin yy = ~y; s = 17'(x) + 17'(yy) + 17'(c); end
         OP_AND: begin ar = 1'b0; r = x & y; end
         OP_OR:  begin ar = 1'b0; r = x | y; end
         OP_XOR: begin ar = 1'b0; r = x ^ y; end
         default: begin ar = 1'b0; r = x; end
      endcase
      if (ar) begin
         r  = s[15:0];
         co = s[16];
         v  = (x[15] == yy[15]) && (r[15] != x[15]);
`ifdef ALU_SEQ_SAT_EN
         if (v) r = (x[15] == 1'b0) ? 16'h7FFF : 16'h8000;
`endif
      end
      return {r, r[15], (r == 16'h0), co, v};
   endfunction

   // Compare process: checks outputs, then advances the model for the next edge.
   always @(negedge clk) begin
      if (go) begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, ~pend});
         if (out_valid) begin
            chk("out_valid_expected", {31'b0, pend}, 32'd1);
            chk("model_result", {16'b0, result}, {16'b0, exp_res});
            chk("model_flags", {28'b0, flags}, {28'b0, exp_flg});
         end
         if (reset) begin
            pend = 1'b0;
            cf   = 1'b0;
         end else if (!pend && in_valid) begin
            {exp_res, exp_flg} = model(op, a, b, cf);
            pend = 1'b1;
         end else if (pend && out_valid && out_ready) begin
            cf   = exp_flg[FLG_C];
            pend = 1'b0;
         end
      end
   end

   task automatic run_op(input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                         input logic [15:0] xr, input logic [3:0] xf,
                         input int stall, input bit pulse);
      int   lat;
      logic rdy;
      in_valid = 1'b1; op = o; a = aa; b = bb;
      lat = 0;
      do begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); #1; lat++;
      end while (!rdy && lat < 20);
      in_valid = 1'b0;
      chk("accept", {31'b0, rdy}, 32'd1);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("latency", lat, 32'd5);
      chk("vec_result", {16'b0, result}, {16'b0, xr});
      chk("vec_flags", {28'b0, flags}, {28'b0, xf});
      for (int i = 0; i < stall; i++) begin
         if (pulse && i == 2) begin
            in_valid = 1'b1; op = OP_ADD; a = 16'h1111; b = 16'h2222;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("back_idle_ready", {31'b0, in_ready}, 32'd1);
      chk("back_idle_valid", {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", {16'b0, result}, 32'd0);
      chk("rst_flags", {28'b0, flags}, 32'd0);
      go = 1'b1;

      run_op(OP_ADD,    16'h7FFF, 16'h0001, R_OVF,    F_OVF,   0, 1'b0);
      run_op(OP_SUB,    16'h0005, 16'h0005, 16'h0000, 4'b0110, 0, 1'b0);
      run_op(OP_SUB,    16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 0, 1'b0);
      run_op(OP_ADD,    16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 0, 1'b0);
      run_op(OP_ADC,    16'h0000, 16'h0000, 16'h0001, 4'b0000, 0, 1'b0);
      run_op(OP_AND,    16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 0, 1'b0);
      run_op(OP_OR,     16'hF0F0, 16'h3C3C, 16'hFCFC, 4'b1000, 6, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("pulse_not_taken_ready", {31'b0, in_ready}, 32'd1);
      chk("pulse_not_taken_valid", {31'b0, out_valid}, 32'd0);
      run_op(OP_XOR,    16'hF0F0, 16'h3C3C, 16'hCCCC, 4'b1000, 0, 1'b0);
      run_op(OP_PASS_A, 16'h1234, 16'hABCD, 16'h1234, 4'b0000, 0, 1'b0);
      run_op(OP_SBB,    16'h0010, 16'h0001, 16'h000E, 4'b0010, 0, 1'b0);
      run_op(OP_SBB,    16'h8000, 16'h0001, R_SBBV,   F_SBBV,  0, 1'b0);

      // Reset during the second RUN cycle of an ADD that would set C.
      in_valid = 1'b1; op = OP_ADD; a = 16'hFFFF; b = 16'h0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_result", {16'b0, result}, 32'd0);
      run_op(OP_ADC,    16'h0000, 16'h0000, 16'h0000, 4'b0100, 0, 1'b0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
